// File: rtl/aes_seq_pkg.sv
// ============================================================================
//  Module  : aes_seq_pkg
//  Brief   : Shared state encoding and constants for the AES round sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package aes_seq_pkg;

    localparam int AES256_NUM_ROUNDS = 14;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } seqState_t;

endpackage

`default_nettype wire

// File: rtl/aes_round_counter.sv
// ============================================================================
//  Module  : aes_round_counter
//  Brief   : Round counter with terminal flag and direction-mapped key index.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_round_counter #(
    parameter int NUM_ROUNDS = 14,
    parameter int RIDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic              i_decrypt,
    output logic [RIDX_W-1:0] o_idx,
    output logic              o_terminal
);

    localparam logic [RIDX_W-1:0] c_NUM_ROUNDS = RIDX_W'(NUM_ROUNDS);

    logic [RIDX_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + RIDX_W'(1);
        end
    end

    // Decryption walks the key schedule backwards from the last round key.
    assign o_idx      = i_decrypt ? (c_NUM_ROUNDS - r_count) : r_count;
    assign o_terminal = (r_count == c_NUM_ROUNDS);

endmodule

`default_nettype wire

// File: rtl/aes_round_sequencer.sv
// ============================================================================
//  Module  : aes_round_sequencer
//  Brief   : Load / round / completion sequencing of the AES round data register.
//            Optional abort input enabled by defining AES_SEQ_ABORT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = AES256_NUM_ROUNDS,
    parameter int DATA_W     = 128,
    parameter int RIDX_W     = 4
) (
    input  logic              inClk,
    input  logic              inRst,
    input  logic              inStart,
    input  logic              inDecrypt,
    input  logic [DATA_W-1:0] inData,
    output logic              outBusy,
    output logic              outExtEncWr,
    output logic              outExtDecWr,
    output logic [DATA_W-1:0] outExtData,
    output logic              outIntEncWr,
    output logic              outIntDecWr,
    output logic [RIDX_W-1:0] outRoundIdx,
    output logic              outLastRound,
    output logic              outDoneValid,
    input  logic              inDoneReady
`ifdef AES_SEQ_ABORT_EN
    ,
    input  logic              inAbort
`endif
);

    seqState_t         r_state;
    seqState_t         w_nextState;
    logic              w_accept;
    logic              w_abort;
    logic              w_nextDec;
    logic              w_terminal;
    logic              r_decrypt;
    logic [DATA_W-1:0] r_extData;
    logic              r_extEncWr;
    logic              r_extDecWr;
    logic              r_intEncWr;
    logic              r_intDecWr;

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        w_abort     = inAbort && ((r_state == ST_LOAD) || (r_state == ST_ROUND));
`endif
        case (r_state)
            ST_IDLE: begin
                if (inStart) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_LOAD;
                end
            end
            ST_LOAD:  w_nextState = ST_ROUND;
            ST_ROUND: begin
                if (w_terminal) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (inDoneReady) begin
                    w_accept    = inStart;
                    w_nextState = inStart ? ST_LOAD : ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (w_abort) begin
            w_nextState = ST_IDLE;
        end
        w_nextDec = w_accept ? inDecrypt : r_decrypt;
    end

    // Strobes are decoded from the next state so they line up with it.
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            r_decrypt  <= MODE_ENC;
            r_extData  <= '0;
            r_extEncWr <= 1'b0;
            r_extDecWr <= 1'b0;
            r_intEncWr <= 1'b0;
            r_intDecWr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_decrypt <= inDecrypt;
                r_extData <= inData;
            end
            r_extEncWr <= (w_nextState == ST_LOAD)  && (w_nextDec == MODE_ENC);
            r_extDecWr <= (w_nextState == ST_LOAD)  && (w_nextDec == MODE_DEC);
            r_intEncWr <= (w_nextState == ST_ROUND) && (w_nextDec == MODE_ENC);
            r_intDecWr <= (w_nextState == ST_ROUND) && (w_nextDec == MODE_DEC);
        end
    end

    aes_round_counter #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .RIDX_W     (RIDX_W)
    ) u_roundCounter (
        .clk        (inClk),
        .rst        (inRst),
        .i_load     (w_accept),
        .i_inc      (w_nextState == ST_ROUND),
        .i_decrypt  (r_decrypt),
        .o_idx      (outRoundIdx),
        .o_terminal (w_terminal)
    );

    // An abort suppresses the strobe already registered for the aborting cycle.
    assign outExtEncWr  = r_extEncWr & ~w_abort;
    assign outExtDecWr  = r_extDecWr & ~w_abort;
    assign outIntEncWr  = r_intEncWr & ~w_abort;
    assign outIntDecWr  = r_intDecWr & ~w_abort;
    assign outLastRound = (r_intEncWr | r_intDecWr) & w_terminal & ~w_abort;
    assign outExtData   = r_extData;
    assign outBusy      = (r_state != ST_IDLE);
    assign outDoneValid = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
// ============================================================================
//  Module  : tb_aes_round_sequencer
//  Brief   : Directed vector table plus randomized run against a queue model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_round_sequencer;

    localparam int NR = 14;

    logic         inClk = 1'b0;
    logic         inRst = 1'b1;
    logic         inStart = 1'b0;
    logic         inDecrypt = 1'b0;
    logic [127:0] inData = '0;
    logic         inDoneReady = 1'b0;
    logic         outBusy, outExtEncWr, outExtDecWr, outIntEncWr, outIntDecWr;
    logic         outLastRound, outDoneValid;
    logic [127:0] outExtData;
    logic [3:0]   outRoundIdx;
`ifdef AES_SEQ_ABORT_EN
    logic         inAbort = 1'b0;
`endif

    always #5 inClk = ~inClk;

    aes_round_sequencer dut (
        .inClk        (inClk),
        .inRst        (inRst),
        .inStart      (inStart),
        .inDecrypt    (inDecrypt),
        .inData       (inData),
        .outBusy      (outBusy),
        .outExtEncWr  (outExtEncWr),
        .outExtDecWr  (outExtDecWr),
        .outExtData   (outExtData),
        .outIntEncWr  (outIntEncWr),
        .outIntDecWr  (outIntDecWr),
        .outRoundIdx  (outRoundIdx),
        .outLastRound (outLastRound),
        .outDoneValid (outDoneValid),
        .inDoneReady  (inDoneReady)
`ifdef AES_SEQ_ABORT_EN
        ,
        .inAbort      (inAbort)
`endif
    );

    typedef struct packed {
        logic       busy, extEnc, extDec, intEnc, intDec, last, done;
        logic [3:0] idx;
    } outs_t;

    typedef struct {
        logic         start, dec, ready;
        logic [127:0] data;
        outs_t        exp;
        logic [127:0] expData;
    } vec_t;

    vec_t  tbl[$];
    outs_t q[$];
    int    nVec = 0;
    int    nFail = 0;

    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D2 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] D3 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] D4 = 128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3c3c;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Index is only defined while a strobe is high.
    task automatic checkOuts(input string name, input outs_t exp);
        outs_t a;
        a = '{busy: outBusy, extEnc: outExtEncWr, extDec: outExtDecWr, intEnc: outIntEncWr,
              intDec: outIntDecWr, last: outLastRound, done: outDoneValid, idx: outRoundIdx};
        if (!(exp.extEnc | exp.extDec | exp.intEnc | exp.intDec)) a.idx = exp.idx;
        check(name, {117'b0, a}, {117'b0, exp});
    endtask

    function automatic outs_t idleRec();
        return '{default: '0};
    endfunction

    function automatic outs_t doneRec();
        outs_t o = '{default: '0};
        o.busy = 1'b1;
        o.done = 1'b1;
        return o;
    endfunction

    // r = 0 is the external load, r = 1..NR are the rounds.
    function automatic outs_t strobeRec(input logic dec, input int r);
        outs_t o = '{default: '0};
        o.busy   = 1'b1;
        o.extEnc = (r == 0) && !dec;
        o.extDec = (r == 0) && dec;
        o.intEnc = (r != 0) && !dec;
        o.intDec = (r != 0) && dec;
        o.last   = (r == NR);
        o.idx    = 4'(dec ? NR - r : r);
        return o;
    endfunction

    task automatic addOp(input logic dec, input logic [127:0] d, input int waitN);
        vec_t v;
        v.start = 1'b1; v.dec = dec; v.ready = 1'b0; v.data = d; v.expData = d;
        v.exp = strobeRec(dec, 0);
        tbl.push_back(v);
        for (int r = 1; r <= NR; r++) begin
            v.start = (r == 7); v.dec = ~dec; v.data = ~d;
            v.exp = strobeRec(dec, r);
            tbl.push_back(v);
        end
        for (int w = 0; w < waitN; w++) begin
            v.start = (w == 2); v.ready = 1'b0;
            v.exp = doneRec();
            tbl.push_back(v);
        end
        v.start = 1'b0; v.ready = 1'b1;
        v.exp = idleRec();
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge inClk);
        @(negedge inClk);
    endtask

    task automatic applyRange(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            inStart = tbl[i].start; inDecrypt = tbl[i].dec;
            inDoneReady = tbl[i].ready; inData = tbl[i].data;
            step();
            checkOuts($sformatf("vec%0d", i), tbl[i].exp);
            check($sformatf("vec%0d_data", i), outExtData, tbl[i].expData);
        end
        inStart = 1'b0; inDoneReady = 1'b0;
    endtask

    task automatic modelAccept(input logic dec);
        q.delete();
        for (int r = 0; r <= NR; r++) q.push_back(strobeRec(dec, r));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n1;
        int phase;
        logic [127:0] mData;
        outs_t e;

        repeat (2) @(negedge inClk);
        checkOuts("reset", idleRec());
        check("reset_idx", {124'b0, outRoundIdx}, 128'd0);
        check("reset_data", outExtData, 128'd0);
        inRst = 1'b0;

        addOp(1'b0, D1, 1);
        n1 = tbl.size();
        addOp(1'b1, D2, 6);
        applyRange(0, tbl.size());

        // Back-to-back start in DONE, with latency check on the first op.
        inStart = 1'b1; inDecrypt = 1'b0; inData = D3;
        step();
        inStart = 1'b0;
        checkOuts("b2b_load", strobeRec(1'b0, 0));
        repeat (NR) step();
        checkOuts("b2b_lastround", strobeRec(1'b0, NR));
        step();
        checkOuts("b2b_done", doneRec());
        inStart = 1'b1; inDoneReady = 1'b1; inDecrypt = 1'b1; inData = D4;
        step();
        inStart = 1'b0; inDoneReady = 1'b0;
        checkOuts("b2b_reload", strobeRec(1'b1, 0));
        check("b2b_data", outExtData, D4);
        repeat (NR) step();
        checkOuts("b2b_dec_last", strobeRec(1'b1, NR));
        step();
        checkOuts("b2b_done2", doneRec());
        inDoneReady = 1'b1;
        step();
        inDoneReady = 1'b0;
        checkOuts("b2b_idle", idleRec());

        // Asynchronous reset in the middle of round 7.
        inStart = 1'b1; inDecrypt = 1'b0; inData = D3;
        step();
        inStart = 1'b0;
        repeat (7) step();
        checkOuts("rst_round7", strobeRec(1'b0, 7));
        #2 inRst = 1'b1;
        #1;
        checkOuts("rst_async", idleRec());
        check("rst_async_idx", {124'b0, outRoundIdx}, 128'd0);
        check("rst_async_data", outExtData, 128'd0);
        @(negedge inClk);
        inRst = 1'b0;
        applyRange(0, n1);

`ifdef AES_SEQ_ABORT_EN
        inStart = 1'b1; inDecrypt = 1'b0; inData = D4;
        step();
        inStart = 1'b0;
        repeat (4) step();
        @(posedge inClk);
        #1 inAbort = 1'b1;
        @(negedge inClk);
        e = idleRec();
        e.busy = 1'b1;
        checkOuts("abort_cycle", e);
        @(posedge inClk);
        #1 inAbort = 1'b0;
        @(negedge inClk);
        checkOuts("abort_idle", idleRec());
        repeat (20) begin
            step();
            checkOuts("abort_nodone", idleRec());
        end
        mData = D4;
`else
        mData = D1;
`endif

        // Randomized run against the queue-based model.
        phase = 0;
        for (int i = 0; i < 3000; i++) begin
            inStart     = 1'($urandom_range(0, 1));
            inDecrypt   = 1'($urandom_range(0, 1));
            inDoneReady = ($urandom_range(0, 2) != 0);
            inData      = {$urandom, $urandom, $urandom, $urandom};
            case (phase)
                0: if (inStart) begin
                    modelAccept(inDecrypt); mData = inData; phase = 1;
                end
                1: begin
                    void'(q.pop_front());
                    if (q.size() == 0) phase = 2;
                end
                default: if (inDoneReady) begin
                    if (inStart) begin
                        modelAccept(inDecrypt); mData = inData; phase = 1;
                    end else begin
                        phase = 0;
                    end
                end
            endcase
            step();
            e = (phase == 1) ? q[0] : (phase == 2) ? doneRec() : idleRec();
            checkOuts($sformatf("rnd%0d", i), e);
            check($sformatf("rnd%0d_data", i), outExtData, mData);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

`default_nettype wire
